// File: rtl/inst_rom_arb_pkg.sv
// Shared constants and types for the instruction ROM arbiter.
// Exports: ADDR_W/INST_W (32), STARVE_W (counter width), REQ_FETCH/REQ_DBG
// requester indices, ZERO_WORD, addr_t/inst_t and a misalignment helper.
package inst_rom_arb_pkg;

  localparam int ADDR_W    = 32;
  localparam int INST_W    = 32;
  localparam int STARVE_W  = 4;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DBG   = 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam inst_t ZERO_WORD = '0;

  // Word accesses only: any nonzero byte offset is a misaligned fetch.
  function automatic logic misaligned(input addr_t a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_rom_arb_starve.sv
// Saturating starvation counter for the debug requester.
// Ports: clk, rst (sync, active-high), dbg_req, dbg_gnt in; force_dbg out,
// high while the count has reached STARVE_LIMIT (debug must win this cycle).
module inst_rom_arb_starve
  import inst_rom_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic force_dbg
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] cnt;

  // Counts consecutive cycles a pending debug request lost; any win or
  // idle cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!dbg_req || dbg_gnt) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_dbg = (cnt == LIMIT);

endmodule

// File: rtl/inst_rom_arb.sv
// Two-requester arbiter (fetch priority, debug starvation override) in front
// of a single-port instruction ROM; read data/valid registered, latency 1.
// Ports: clk, rst (sync, active-high); fetch_* and dbg_* req/addr/gnt/valid/
// data/err per requester; rom_ce/rom_addr out, rom_inst in (combinational).
// Optional: define INST_ROM_ARB_ALIGN_CHK_EN to flag misaligned addresses
// (no ROM access, valid with err=1 and zero data).
module inst_rom_arb
  import inst_rom_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [INST_W-1:0] fetch_inst,
  output logic              fetch_err,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_valid,
  output logic [INST_W-1:0] dbg_data,
  output logic              dbg_err,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst
);

  logic       force_dbg;
  logic       dbg_win;
  logic [1:0] gnt;
  addr_t      win_addr;
  inst_t      rd_word;

  inst_rom_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .dbg_req   (dbg_req),
    .dbg_gnt   (gnt[REQ_DBG]),
    .force_dbg (force_dbg)
  );

  // Debug wins when fetch is idle or debug has starved long enough.
  // Reset masks both grants so nothing is launched during reset.
  assign dbg_win        = dbg_req & (~fetch_req | force_dbg);
  assign gnt[REQ_DBG]   = ~rst & dbg_win;
  assign gnt[REQ_FETCH] = ~rst & fetch_req & ~dbg_win;

  assign fetch_gnt = gnt[REQ_FETCH];
  assign dbg_gnt   = gnt[REQ_DBG];

  always_comb begin
    win_addr = '0;
    if (gnt[REQ_DBG]) begin
      win_addr = dbg_addr;
    end else if (gnt[REQ_FETCH]) begin
      win_addr = fetch_addr;
    end
  end

  assign rom_addr = win_addr;

`ifdef INST_ROM_ARB_ALIGN_CHK_EN
  logic win_mis;

  // A misaligned winner still consumes the slot but never touches the ROM.
  assign win_mis = misaligned(win_addr);
  assign rom_ce  = (|gnt) & ~win_mis;
  assign rd_word = win_mis ? ZERO_WORD : rom_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_err <= 1'b0;
      dbg_err   <= 1'b0;
    end else begin
      fetch_err <= gnt[REQ_FETCH] & win_mis;
      dbg_err   <= gnt[REQ_DBG] & win_mis;
    end
  end
`else
  assign rom_ce    = |gnt;
  assign rd_word   = rom_inst;
  assign fetch_err = 1'b0;
  assign dbg_err   = 1'b0;
`endif

  // Winner captures the ROM word; loser holds its data and sees no valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      dbg_valid   <= 1'b0;
      fetch_inst  <= ZERO_WORD;
      dbg_data    <= ZERO_WORD;
    end else begin
      fetch_valid <= gnt[REQ_FETCH];
      dbg_valid   <= gnt[REQ_DBG];
      if (gnt[REQ_FETCH]) fetch_inst <= rd_word;
      if (gnt[REQ_DBG])   dbg_data   <= rd_word;
    end
  end

endmodule

// File: doc/inst_rom_arb.md
# inst_rom_arb

Two-requester arbiter in front of the single-port instruction ROM. It shares the ROM between the pipeline fetch stage (`fetch_*`) and the debug/loader read port (`dbg_*`), which dumps ROM contents over the debug link. Fetch has default priority, and a starvation counter guarantees forward progress for debug. ROM read data is registered and returned with a one-cycle valid pulse to the granted requester.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles a pending debug request may lose before it is forced through; legal range 1..15.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: **synchronous, active-high reset**.
- `fetch_req` input 1: fetch read request.
- `fetch_addr` input 32: byte address; held stable while `fetch_req` is high and not yet granted.
- `fetch_gnt` output 1: combinational; request accepted this cycle.
- `fetch_valid` output 1: registered; `fetch_inst` is valid this cycle.
- `fetch_inst` output 32: registered read data.
- `fetch_err` output 1: registered; misaligned-access flag.
- `dbg_req`, `dbg_addr`[32], `dbg_gnt`, `dbg_valid`, `dbg_data`[32], `dbg_err`: same semantics for the debug requester.
- `rom_ce` output 1: ROM chip enable.
- `rom_addr` output 32: ROM byte address.
- `rom_inst` input 32: ROM read data; combinational from `rom_ce`/`rom_addr`.

## Operation
- **Grant rule:**
  - Debug is granted when `dbg_req` is high and either `fetch_req` is low or `starve_cnt` equals `STARVE_LIMIT`.
  - Otherwise fetch is granted if `fetch_req` is high.
  - At most one grant per cycle.
- **Starvation counter (4 bit):**
  - Increments when `dbg_req` is high and `dbg_gnt` is low.
  - Clears on `dbg_gnt` or when `dbg_req` is low.
  - Saturates at `STARVE_LIMIT`.
- **ROM drive:**
  - `rom_ce` equals the OR of the two grants.
  - `rom_addr` is the winner's address, or 0 when there is no grant.
- **Capture:** on the clock edge after a grant, `rom_inst` is latched into the winner's data register and the winner's valid bit is set for exactly one cycle.
- The loser's data register holds its previous value, and its valid bit is 0.
- **Back-to-back requests:** a requester may keep `req` high across cycles, and each granted cycle yields one valid cycle. Throughput is one read per cycle in total.
- Requests are not queued. An ungranted requester keeps `req` and `addr` asserted until granted.

## Timing
- Grant is combinational in cycle N. Data and valid appear in cycle N+1, so latency is 1.
- Reset values: `fetch_valid` = `dbg_valid` = 0, `fetch_inst` = `dbg_data` = 0, `fetch_err` = `dbg_err` = 0, `starve_cnt` = 0.
- Combinational outputs depend only on the inputs and `starve_cnt`. While `rst` is high, `fetch_gnt`, `dbg_gnt` and `rom_ce` are forced to 0.
- **Reset mid-operation:** a grant in the cycle `rst` is high is suppressed, so no valid follows. A valid pending from the cycle before reset is cleared at that reset edge.
- **Simultaneous requests with `starve_cnt` < `STARVE_LIMIT`:** fetch wins and the counter increments.
- **Counter at `STARVE_LIMIT`:** debug wins, and the counter returns to 0 on the next edge.

## Configuration
- `INST_ROM_ARB_ALIGN_CHK_EN` defined:
  - A granted address with bits [1:0] != 0 is still granted and consumes the cycle, but `rom_ce` stays 0.
  - In cycle N+1 the winner sees valid = 1, err = 1 and data = 0.
  - Aligned accesses return err = 0.
- Undefined: no alignment check. Bits [1:0] pass through to `rom_addr`, and `fetch_err`/`dbg_err` are tied to 0.

## Structure
- Shared package `inst_rom_arb_pkg` holds:
  - Address and instruction width constants (32).
  - Requester index constants `REQ_FETCH` = 0 and `REQ_DBG` = 1.
  - The zero-word constant.
- One sub-module, `inst_rom_arb_starve`: the saturating starvation counter. Its output `force_dbg` means count == `STARVE_LIMIT`.
- Grant logic and output registers live in the top module.

## Test plan
- **Fetch only:** `fetch_req` = 1 at 0x0, 0x4, 0x8 on consecutive cycles with the ROM preloaded 0x34011100, 0x34020020, 0x3403ff00 -> `fetch_gnt` = 1 each cycle, then `fetch_valid` = 1 for three cycles with those words in order.
- **Starvation:** `fetch_req` held at 1 and `dbg_req` = 1 at 0x10, `STARVE_LIMIT` = 4 -> fetch granted 4 cycles, debug granted in cycle 5, `dbg_valid` in cycle 6 with word[4], fetch re-granted in cycle 6.
- **Debug alone:** `dbg_req` at 0x20 while fetch is idle -> immediate `dbg_gnt`; `dbg_valid` next cycle; `fetch_valid` stays 0.
- **Reset mid-operation:** fetch granted in cycle N, `rst` = 1 in cycle N+1 -> `fetch_valid` = 0 after the reset edge, all outputs at reset values, `rom_ce` = 0 while `rst` is high.
- **Misaligned, macro defined:** `fetch_addr` = 0x6 -> `rom_ce` = 0, next cycle `fetch_valid` = 1, `fetch_err` = 1, `fetch_inst` = 0.
- **Misaligned, macro undefined:** `fetch_addr` = 0x6 -> `rom_addr` = 0x6, `fetch_err` = 0.
